// File: rtl/seg4x7_scan_capture_if.sv
// Scanned 7-segment display bus plus the decoded-frame results published by the capture block.
interface seg4x7_scan_capture_if;
  logic [3:0]  digit_sel;
  logic [7:0]  seg;
  logic [31:0] ascii;
  logic        valid;
  logic        unknown;
  logic        frame_err;
  logic        stale;

  modport master (
    output digit_sel, seg,
    input  ascii, valid, unknown, frame_err, stale
  );

  modport slave (
    input  digit_sel, seg,
    output ascii, valid, unknown, frame_err, stale
  );
endinterface

// File: rtl/seg4x7_scan_capture.sv
// Samples a multiplexed 4-digit 7-segment bus, decodes each digit back to ASCII and
// publishes a 4-character frame once it has been seen FRAMES_STABLE times in a row.
module seg4x7_scan_capture #(
  parameter int unsigned SETTLE        = 16,
  parameter int unsigned FRAMES_STABLE = 2,
  parameter int unsigned TIMEOUT_W     = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  seg4x7_scan_capture_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

  state_t              state_q, state_d;
  logic [3:0]          sel_m, sel_s;
  logic [7:0]          seg_m, seg_s;
  logic [11:0]         bus_last;
  logic [7:0]          settle_cnt;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic [3:0][7:0]     frame_q;
  logic [3:0]          seen_q;
  logic [31:0]         prev_frame;
  logic [3:0]          match_cnt;
  logic [31:0]         ascii_q;
  logic                valid_q, unknown_q, frame_err_q, stale_q;

  logic       bus_changed, settle_hit, cap_ok, cap_err, timeout, frame_done;
  logic       frame_same, publish, frame_unknown;
  logic [3:0] match_next;
  logic [7:0] seg_char;

  function automatic logic [7:0] decode(input logic [7:0] s);
    logic [7:0] c;
    case (s)
      8'hFF: c = 8'h20;  8'hFD: c = 8'h2E;
      8'h0A: c = "0";    8'h6F: c = "1";    8'h32: c = "2";    8'h23: c = "3";
      8'h47: c = "4";    8'h83: c = "5";    8'h82: c = "6";    8'h2F: c = "7";
      8'h02: c = "8";    8'h03: c = "9";
      8'h06: c = "A";    8'hC2: c = "B";    8'h9A: c = "C";    8'h62: c = "D";
      8'h92: c = "E";    8'h96: c = "F";    8'h8A: c = "G";    8'h46: c = "H";
      8'hDE: c = "I";    8'h6B: c = "J";    8'hDA: c = "L";    8'hE6: c = "N";
      8'hE2: c = "O";    8'h16: c = "P";    8'h07: c = "Q";    8'hF6: c = "R";
      8'hD2: c = "T";    8'hEA: c = "U";    8'h5B: c = "W";    8'h43: c = "Y";
      8'hB3: c = "Z";    8'hF7: c = 8'h2D;
      default: c = 8'h3F;
    endcase
    return c;
  endfunction

  assign bus_changed = {sel_s, seg_s} != bus_last;
  // Only the SETTLE-1 -> SETTLE step captures, so one stable period yields one capture.
  assign settle_hit  = !bus_changed && (settle_cnt == 8'(SETTLE - 1));
  assign cap_ok      = settle_hit && $onehot(sel_s);
  assign cap_err     = settle_hit && !$onehot(sel_s) && (sel_s != 4'h0);
  assign timeout     = (wd_cnt == '1) && !cap_ok;
  assign frame_done  = cap_ok && ((seen_q | sel_s) == 4'hF);
  assign seg_char    = decode(seg_s);

  assign frame_same  = frame_q == prev_frame;
  assign match_next  = !frame_same ? 4'd1 : (match_cnt == 4'hF ? 4'hF : match_cnt + 4'd1);
  // A saturated count that stays put must not publish the same frame again.
  assign publish     = (state_q == CHECK) && (match_next == 4'(FRAMES_STABLE))
                       && (!frame_same || match_cnt != match_next);

  always_comb begin
    frame_unknown = 1'b0;
    for (int unsigned n = 0; n < 4; n++)
      if (frame_q[n] == 8'h3F) frame_unknown = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cap_ok) state_d = COLLECT;
      COLLECT: if (frame_done) state_d = CHECK;
      CHECK:   state_d = COLLECT;
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_m       <= '0;
      sel_s       <= '0;
      seg_m       <= '1;
      seg_s       <= '1;
      bus_last    <= {4'h0, 8'hFF};
      settle_cnt  <= '0;
      wd_cnt      <= '0;
      frame_q     <= '0;
      seen_q      <= '0;
      prev_frame  <= '0;
      match_cnt   <= '0;
      ascii_q     <= 32'h20202020;
      valid_q     <= 1'b0;
      unknown_q   <= 1'b0;
      frame_err_q <= 1'b0;
      stale_q     <= 1'b1;
    end else begin
      sel_m    <= bus.digit_sel;
      sel_s    <= sel_m;
      seg_m    <= bus.seg;
      seg_s    <= seg_m;
      bus_last <= {sel_s, seg_s};

      if (bus_changed)                   settle_cnt <= '0;
      else if (settle_cnt != 8'(SETTLE)) settle_cnt <= settle_cnt + 8'd1;

      valid_q     <= publish;
      frame_err_q <= cap_err;

      if (cap_ok) begin
        for (int unsigned n = 0; n < 4; n++)
          if (sel_s[n]) frame_q[n] <= seg_char;
        seen_q  <= seen_q | sel_s;
        wd_cnt  <= '0;
        stale_q <= 1'b0;
      end else if (wd_cnt != '1) begin
        wd_cnt <= wd_cnt + TIMEOUT_W'(1);
      end

      if (state_q == CHECK) begin
        seen_q     <= '0;
        prev_frame <= frame_q;
        match_cnt  <= match_next;
        if (publish) begin
          ascii_q   <= frame_q;
          unknown_q <= frame_unknown;
        end
      end

      if (timeout) begin
        stale_q    <= 1'b1;
        seen_q     <= '0;
        match_cnt  <= '0;
        prev_frame <= '0;
      end
    end
  end

  assign bus.ascii     = ascii_q;
  assign bus.valid     = valid_q;
  assign bus.unknown   = unknown_q;
  assign bus.frame_err = frame_err_q;
  assign bus.stale     = stale_q;

endmodule

// File: tb/tb_seg4x7_scan_capture.sv
// Directed and randomized scans of the display bus, checked against a frame-level model.
module tb_seg4x7_scan_capture;
  localparam int unsigned SETTLE = 16;
  localparam int unsigned FS     = 2;
  localparam int unsigned TW     = 10;
  localparam int          LONG   = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg4x7_scan_capture_if bus();

  seg4x7_scan_capture #(.SETTLE(SETTLE), .FRAMES_STABLE(FS), .TIMEOUT_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int valid_seen = 0;
  int ferr_seen  = 0;

  always @(negedge clk) begin
    if (bus.valid)     valid_seen++;
    if (bus.frame_err) ferr_seen++;
  end

  logic [7:0] seg_tab [34] = '{8'hFF, 8'hFD, 8'h0A, 8'h6F, 8'h32, 8'h23, 8'h47, 8'h83, 8'h82,
                               8'h2F, 8'h02, 8'h03, 8'h06, 8'hC2, 8'h9A, 8'h62, 8'h92, 8'h96,
                               8'h8A, 8'h46, 8'hDE, 8'h6B, 8'hDA, 8'hE6, 8'hE2, 8'h16, 8'h07,
                               8'hF6, 8'hD2, 8'hEA, 8'h5B, 8'h43, 8'hB3, 8'hF7};
  string chr_tab = " .0123456789ABCDEFGHIJLNOPQRTUWYZ-";

  // Frame-level model state
  logic [7:0]  m_slot [4];
  logic [3:0]  m_seen;
  logic [31:0] m_prev, m_ascii;
  int          m_cnt, m_valid, m_ferr;
  logic        m_unknown, m_stale;

  function automatic logic [7:0] m_dec(input logic [7:0] s);
    for (int i = 0; i < 34; i++)
      if (seg_tab[i] == s) return chr_tab[i];
    return 8'h3F;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_slot[i] = 8'h00;
    m_seen = 4'h0; m_prev = '0; m_cnt = 0;
    m_ascii = 32'h20202020; m_unknown = 1'b0; m_stale = 1'b1;
  endtask

  task automatic m_capture(input logic [3:0] sel, input logic [7:0] s);
    logic [31:0] frame;
    int old;
    for (int i = 0; i < 4; i++)
      if (sel[i]) begin m_slot[i] = m_dec(s); m_seen[i] = 1'b1; end
    m_stale = 1'b0;
    if (m_seen == 4'hF) begin
      frame = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
      old   = m_cnt;
      if (frame == m_prev) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      else                 m_cnt = 1;
      if (m_cnt == FS && !(frame == m_prev && old == m_cnt)) begin
        m_ascii   = frame;
        m_unknown = (m_slot[0] == 8'h3F) || (m_slot[1] == 8'h3F) ||
                    (m_slot[2] == 8'h3F) || (m_slot[3] == 8'h3F);
        m_valid++;
      end
      m_prev = frame;
      m_seen = 4'h0;
    end
  endtask

  task automatic m_timeout();
    m_stale = 1'b1; m_seen = 4'h0; m_cnt = 0; m_prev = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ascii"},   bus.ascii,             m_ascii);
    chk({tag, ".unknown"}, {31'd0, bus.unknown},  {31'd0, m_unknown});
    chk({tag, ".stale"},   {31'd0, bus.stale},    {31'd0, m_stale});
    chk({tag, ".valids"},  valid_seen,            m_valid);
    chk({tag, ".ferrs"},   ferr_seen,             m_ferr);
  endtask

  // Holds shorter than the settle window never capture; LONG holds always do.
  task automatic present(input string tag, input logic [3:0] sel, input logic [7:0] s, input int hold);
    @(negedge clk);
    bus.digit_sel = sel;
    bus.seg       = s;
    repeat (hold) @(negedge clk);
    #1;
    if (hold >= 24) begin
      if ($onehot(sel))     m_capture(sel, s);
      else if (sel != 4'h0) m_ferr++;
    end
    check_all(tag);
  endtask

  task automatic scan(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic [7:0] s3);
    present(tag, 4'b0001, s0, LONG);
    present(tag, 4'b0010, s1, LONG);
    present(tag, 4'b0100, s2, LONG);
    present(tag, 4'b1000, s3, LONG);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_reset();
    chk({tag, ".valid"},     {31'd0, bus.valid},     32'd0);
    chk({tag, ".frame_err"}, {31'd0, bus.frame_err}, 32'd0);
    check_all(tag);
    bus.digit_sel = 4'h0;
    bus.seg       = 8'hFF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] s [4];
    int reps;
    reset = 1'b1;
    bus.digit_sel = 4'h0;
    bus.seg = 8'hFF;
    m_valid = 0; m_ferr = 0;
    m_reset();
    repeat (2) @(negedge clk);
    do_reset("reset");

    scan("t1_f1", 8'h0A, 8'h6F, 8'h32, 8'h23);
    scan("t1_f2", 8'h0A, 8'h6F, 8'h32, 8'h23);
    chk("t1_ascii_0123", bus.ascii, 32'h33323130);
    chk("t1_one_valid", valid_seen, 1);

    scan("t2_f3", 8'h0A, 8'h6F, 8'h32, 8'h23);
    chk("t2_no_repub", valid_seen, 1);

    present("t3_glitch", 4'b0001, 8'h6F, 10);
    present("t3_settled", 4'b0001, 8'h0A, LONG);
    present("t3", 4'b0010, 8'h6F, LONG);
    present("t3", 4'b0100, 8'h32, LONG);
    present("t3", 4'b1000, 8'h23, LONG);
    chk("t3_still_one_valid", valid_seen, 1);

    scan("t4_f1", 8'h0A, 8'h6F, 8'h00, 8'h23);
    scan("t4_f2", 8'h0A, 8'h6F, 8'h00, 8'h23);
    chk("t4_ascii_unk", bus.ascii, 32'h333F3130);
    chk("t4_unknown", {31'd0, bus.unknown}, 32'd1);

    present("t5", 4'b0001, 8'h0A, LONG);
    present("t5", 4'b0010, 8'h6F, LONG);
    present("t5_multi", 4'b0011, 8'h32, LONG);
    chk("t5_one_ferr", ferr_seen, 1);
    present("t5", 4'b0100, 8'h32, LONG);
    present("t5", 4'b1000, 8'h23, LONG);
    scan("t5_f2", 8'h0A, 8'h6F, 8'h32, 8'h23);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 4; i++)
        s[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : seg_tab[$urandom_range(0, 33)];
      reps = $urandom_range(1, 3);
      for (int r = 0; r < reps; r++) scan("rand", s[0], s[1], s[2], s[3]);
    end

    for (int f = 0; f < 5; f++)
      scan("t6_alt", 8'h06, 8'hC2, 8'h9A, (f % 2 == 0) ? 8'h62 : 8'h92);
    reps = valid_seen;
    present("t6_part", 4'b0001, 8'h06, LONG);
    present("t6_part", 4'b0010, 8'hC2, LONG);
    chk("t6_no_valid_alt", valid_seen, reps);
    @(negedge clk);
    bus.digit_sel = 4'h0;
    bus.seg = 8'hFF;
    repeat ((1 << TW) + 80) @(negedge clk);
    #1;
    m_timeout();
    check_all("t6_timeout");
    present("t6_after", 4'b0100, 8'h9A, LONG);
    present("t6_after", 4'b1000, 8'h62, LONG);
    scan("t6_f1", 8'h06, 8'hC2, 8'h9A, 8'h62);
    scan("t6_f2", 8'h06, 8'hC2, 8'h9A, 8'h62);
    chk("t6_ascii_abcd", bus.ascii, 32'h44434241);

    present("t7_part", 4'b0001, 8'h23, LONG);
    present("t7_part", 4'b0010, 8'h32, LONG);
    do_reset("t7_reset");
    scan("t7_f1", 8'h0A, 8'h6F, 8'h32, 8'h23);
    scan("t7_f2", 8'h0A, 8'h6F, 8'h32, 8'h23);
    chk("t7_ascii_0123", bus.ascii, 32'h33323130);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
